// File: rtl/huffman_bit_packer.sv
// huffman_bit_packer: packs {length, code} FIFO entries MSB-first into 32-bit words with a flush/pad tail.
// HUFF_PACK_LEN_CHECK_EN defined: lengths >15 are dropped and flagged on sticky len_err.
module huffman_bit_packer #(
    parameter int OUT_W = 32,
    parameter int ACC_W = 48
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic [19:0]      fifo_dout,
    input  logic             fifo_valid,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic             flush,
    output logic [OUT_W-1:0] pk_data,
    output logic             pk_valid,
    input  logic             pk_ready,
    output logic             pk_last,
    output logic [5:0]       pk_nbits,
    output logic             flush_done,
    output logic             len_err
);
    typedef enum logic [1:0] {RUN, DRAIN, PAD, DONE} state_t;
    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d, acc_s;
    logic [5:0]       cnt_q, cnt_d, cnt_s;
    logic             inflight_q;
    logic [3:0]       len;
    logic [14:0]      code_m;
    logic             bad, hs, active;
`ifdef HUFF_PACK_LEN_CHECK_EN
    logic             len_err_q;
    assign bad     = fifo_valid & fifo_dout[19];
    assign len_err = len_err_q;
    always_ff @(posedge clk or negedge rstN)
        if (!rstN) len_err_q <= 1'b0;
        else       len_err_q <= len_err_q | bad;
`else
    logic             unused_len_msb;
    assign unused_len_msb = fifo_dout[19];
    assign bad            = 1'b0;
    assign len_err        = 1'b0;
`endif
    always_comb begin
        active     = state_q == RUN || state_q == DRAIN;
        pk_valid   = (active && cnt_q >= 6'd32) || state_q == PAD;
        pk_data    = acc_q[ACC_W-1 -: OUT_W];
        pk_last    = state_q == PAD;
        pk_nbits   = pk_last ? cnt_q : (pk_valid ? 6'd32 : 6'd0);
        flush_done = state_q == DONE;
        // The in-flight read can land up to 15 more bits, so leave room for two entries.
        fifo_rd_en = !fifo_empty && active && (inflight_q ? cnt_q <= 6'd18 : cnt_q <= 6'd33);
        hs         = pk_valid && pk_ready;
        len        = bad ? 4'd0 : fifo_dout[18:15];
        code_m     = fifo_dout[14:0] & ~(15'h7fff << len);
        acc_s      = hs ? acc_q << OUT_W : acc_q;
        cnt_s      = hs ? cnt_q - 6'd32 : cnt_q;
        acc_d      = fifo_valid ? acc_s | ({{(ACC_W-15){1'b0}}, code_m} << (6'(ACC_W) - cnt_s - {2'b0, len})) : acc_s;
        cnt_d      = fifo_valid ? cnt_s + {2'b0, len} : cnt_s;
        state_d    = state_q;
        if (state_q == RUN && flush)
            state_d = DRAIN;
        if (state_q == DRAIN && fifo_empty && !inflight_q && !fifo_valid && cnt_q < 6'd32)
            state_d = PAD;
        if (state_q == PAD && hs) begin
            state_d = DONE;
            acc_d   = '0;
            cnt_d   = '0;
        end
        if (state_q == DONE)
            state_d = RUN;
    end
    always_ff @(posedge clk or negedge rstN)
        if (!rstN) begin
            state_q    <= RUN;
            acc_q      <= '0;
            cnt_q      <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            inflight_q <= fifo_rd_en;
        end
endmodule

// File: tb/tb_huffman_bit_packer.sv
// tb_huffman_bit_packer: random and directed blocks checked against a bit-queue model of the packed stream.
module tb_huffman_bit_packer;
    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic [19:0] fifo_dout;
    logic        fifo_valid;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic        flush = 1'b0;
    logic [31:0] pk_data;
    logic        pk_valid;
    logic        pk_ready = 1'b0;
    logic        pk_last;
    logic [5:0]  pk_nbits;
    logic        flush_done;
    logic        len_err;

    huffman_bit_packer dut (
        .clk(clk), .rstN(rstN), .fifo_dout(fifo_dout), .fifo_valid(fifo_valid),
        .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .flush(flush),
        .pk_data(pk_data), .pk_valid(pk_valid), .pk_ready(pk_ready), .pk_last(pk_last),
        .pk_nbits(pk_nbits), .flush_done(flush_done), .len_err(len_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int ready_mode = 2;
    int fd_pending = 0;
    bit done_seen = 0;
    bit exp_len_err = 0;
    bit exp_q[$];
    logic [19:0] mem [0:4095];
    int wr_ptr = 0;
    int rd_ptr = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int eff_len(input logic [4:0] l);
`ifdef HUFF_PACK_LEN_CHECK_EN
        return (l > 5'd15) ? 0 : int'(l);
`else
        return int'(l[3:0]);
`endif
    endfunction

    task automatic push(input logic [4:0] l, input logic [14:0] c);
        int e;
        e = eff_len(l);
        mem[wr_ptr] = {l, c};
        wr_ptr++;
        for (int i = e - 1; i >= 0; i--) exp_q.push_back(c[i]);
`ifdef HUFF_PACK_LEN_CHECK_EN
        if (l > 5'd15) exp_len_err = 1;
`endif
    endtask

    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk or negedge rstN)
        if (!rstN) begin
            fifo_valid <= 1'b0;
            fifo_dout  <= '0;
            rd_ptr     <= wr_ptr;
        end else begin
            fifo_valid <= fifo_rd_en;
            if (fifo_rd_en) begin
                fifo_dout <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + 1;
            end
        end

    always @(posedge clk) begin
        #1;
        pk_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    int n;
    bit lst;
    logic [31:0] w;
    always @(negedge clk)
        if (rstN) begin
            check("flush_done", flush_done, fd_pending[0]);
            if (flush_done) done_seen = 1;
            fd_pending = 0;
            check("cnt_le_48", dut.cnt_q <= 6'd48, 1);
            check("rd_en_when_empty", fifo_rd_en & fifo_empty, 0);
            if (pk_valid && pk_ready) begin
                lst = exp_q.size() < 32;
                n = lst ? exp_q.size() : 32;
                w = '0;
                for (int i = 0; i < n; i++) w[31-i] = exp_q[i];
                repeat (n) void'(exp_q.pop_front());
                check("pk_data", pk_data, w);
                check("pk_nbits", pk_nbits, n);
                check("pk_last", pk_last, lst);
                if (lst) fd_pending = 1;
            end
        end

    task automatic finish_block();
        int t;
        repeat (2) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        t = 0;
        while (!done_seen && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("block_done", done_seen, 1);
        done_seen = 0;
        @(negedge clk);
        check("len_err", len_err, exp_len_err);
        check("residue_bits", exp_q.size(), 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, pk_valid, 0);
        check({tag, "_data"}, pk_data, 0);
        check({tag, "_last"}, pk_last, 0);
        check({tag, "_nbits"}, pk_nbits, 0);
        check({tag, "_done"}, flush_done, 0);
        check({tag, "_len_err"}, len_err, 0);
        check({tag, "_rd_en"}, fifo_rd_en, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        logic [4:0] l;
        #1;
        check_idle_outputs("reset");
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        ready_mode = 0;
        @(negedge clk);
        // 0xA53CFF01 full word, then 0xABC padded as the last word
        push(5'd8, 15'h00A5);
        push(5'd8, 15'h003C);
        push(5'd8, 15'h00FF);
        push(5'd8, 15'h0001);
        push(5'd12, 15'h0ABC);
        finish_block();
        push(5'd0, 15'h7FFF);
        push(5'd16, 15'h0000);
        push(5'd0, 15'h1234);
        push(5'd16, 15'h7FFF);
        push(5'd15, 15'h7FFF);
        push(5'd0, 15'h5555);
        push(5'd15, 15'h0000);
        push(5'd0, 15'h0001);
        finish_block();
        finish_block();
        push(5'd17, 15'h0001);
        push(5'd9, 15'h0155);
        finish_block();
        ready_mode = 2;
        for (int i = 0; i < 200; i++) begin
            if (i < 24) l = 5'($urandom_range(8, 15));
            else if ($urandom_range(0, 19) == 0) l = 5'($urandom_range(16, 17));
            else l = 5'($urandom_range(0, 15));
            push(l, 15'($urandom));
        end
        repeat (20) @(negedge clk);
        check("rd_stall_ready_low", fifo_rd_en, 0);
        ready_mode = 1;
        finish_block();
        ready_mode = 2;
        for (int i = 0; i < 4; i++) push(5'd10, 15'($urandom));
        t = 0;
        while (!pk_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("fill_to_40", dut.cnt_q, 40);
        rstN = 1'b0;
        exp_q.delete();
        exp_len_err = 0;
        fd_pending = 0;
        done_seen = 0;
        #1;
        check_idle_outputs("midreset");
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        ready_mode = 1;
        for (int i = 0; i < 40; i++) push(5'($urandom_range(0, 15)), 15'($urandom));
        finish_block();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
